// File: rtl/rv32v_types_pkg.sv
// Shared vector types and sizing for the execute sequencer and its element locators.
package rv32v_types_pkg;

  localparam int unsigned VLEN     = 128;
  localparam int unsigned VL_WIDTH = 7;
  localparam int unsigned OFFSET_W = $clog2(VLEN / 8);

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2
  } sew_t;

  typedef logic [OFFSET_W-1:0] offset_t;

endpackage

// File: rtl/rv32v_execute_sequencer_if.sv
// Decode-to-sequencer op handshake plus the two-lane beat stream towards the register file.
interface rv32v_execute_sequencer_if
  import rv32v_types_pkg::*;
#(
  parameter int unsigned VLEN     = rv32v_types_pkg::VLEN,
  parameter int unsigned VL_WIDTH = rv32v_types_pkg::VL_WIDTH
);

  logic                in_valid;
  logic                in_ready;
  logic [VL_WIDTH:0]   vl;
  logic [VL_WIDTH:0]   vstart;
  sew_t                sew;
  logic [4:0]          vd;
  logic                is_masked;
  logic [VLEN-1:0]     v0_mask;
  logic                stall;
  logic                flush;
  logic                beat_valid;
  offset_t             woffset0;
  offset_t             woffset1;
  logic [4:0]          vd_sel0;
  logic [4:0]          vd_sel1;
  logic                lane_en0;
  logic                lane_en1;
  logic                last;
  logic                busy;
  logic                done;

  modport master (
    output in_valid, vl, vstart, sew, vd, is_masked, v0_mask, stall, flush,
    input  in_ready, beat_valid, woffset0, woffset1, vd_sel0, vd_sel1,
    input  lane_en0, lane_en1, last, busy, done
  );

  modport slave (
    input  in_valid, vl, vstart, sew, vd, is_masked, v0_mask, stall, flush,
    output in_ready, beat_valid, woffset0, woffset1, vd_sel0, vd_sel1,
    output lane_en0, lane_en1, last, busy, done
  );

endinterface

// File: rtl/rv32v_elem_locator.sv
// Maps an element index to its register-group member and offset for the given element width.
module rv32v_elem_locator
  import rv32v_types_pkg::*;
#(
  parameter int unsigned ELEM_W = VL_WIDTH + 2
) (
  input  logic [ELEM_W-1:0] elem,
  input  sew_t              sew,
  input  logic [4:0]        vd,
  output offset_t           woffset,
  output logic [4:0]        vd_sel
);

  int unsigned epr_log2;

  always_comb begin
    unique case (sew)
      SEW_16:  epr_log2 = OFFSET_W - 1;
      SEW_32:  epr_log2 = OFFSET_W - 2;
      default: epr_log2 = OFFSET_W;
    endcase
    woffset = offset_t'(elem & ((ELEM_W'(1) << epr_log2) - ELEM_W'(1)));
    // Register index wraps modulo 32 by truncation.
    vd_sel  = 5'(ELEM_W'(vd) + (elem >> epr_log2));
  end

endmodule

// File: rtl/rv32v_execute_sequencer.sv
// Steps a decoded vector op through its elements two per beat, with masking, stall and flush.
module rv32v_execute_sequencer
  import rv32v_types_pkg::*;
#(
  parameter int unsigned VLEN     = rv32v_types_pkg::VLEN,
  parameter int unsigned VL_WIDTH = rv32v_types_pkg::VL_WIDTH
) (
  input logic                     CLK,
  input logic                     RST,
  rv32v_execute_sequencer_if.slave io
);

  localparam int unsigned IDX_W  = VL_WIDTH + 1;
  localparam int unsigned ELEM_W = VL_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  vl_q, vl_d;
  sew_t              sew_q, sew_d;
  logic [4:0]        vd_q, vd_d;
  logic              masked_q, masked_d;
  logic [VLEN-1:0]   v0_q, v0_d;

  logic              accept;
  logic              run;
  logic              last_beat;
  logic [ELEM_W-1:0] elem0, elem1;

  assign accept    = io.in_valid && (state_q == IDLE) && !io.flush;
  assign run       = (state_q == RUN);
  assign elem0     = ELEM_W'(idx_q);
  assign elem1     = elem0 + ELEM_W'(1);
  assign last_beat = (elem0 + ELEM_W'(2)) >= ELEM_W'(vl_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      vl_q     <= '0;
      sew_q    <= SEW_8;
      vd_q     <= '0;
      masked_q <= 1'b0;
      v0_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      vl_q     <= vl_d;
      sew_q    <= sew_d;
      vd_q     <= vd_d;
      masked_q <= masked_d;
      v0_q     <= v0_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    vl_d     = vl_q;
    sew_d    = sew_q;
    vd_d     = vd_q;
    masked_d = masked_q;
    v0_d     = v0_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d    = io.vstart;
          vl_d     = io.vl;
          sew_d    = io.sew;
          vd_d     = io.vd;
          masked_d = io.is_masked;
          v0_d     = io.v0_mask;
          // An empty range still completes through DONE so decode sees a done pulse.
          state_d  = (io.vstart < io.vl) ? RUN : DONE;
        end
      end
      RUN: begin
        if (!io.stall) begin
          idx_d = idx_q + IDX_W'(2);
          if (last_beat) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (io.flush) state_d = IDLE;
  end

  always_comb begin
    io.in_ready   = (state_q == IDLE);
    io.beat_valid = run;
    io.busy       = (state_q != IDLE);
    io.done       = (state_q == DONE);
    io.last       = run && last_beat;
    io.lane_en0   = run && (elem0 < ELEM_W'(vl_q)) && (!masked_q || 1'(v0_q >> elem0));
    io.lane_en1   = run && (elem1 < ELEM_W'(vl_q)) && (!masked_q || 1'(v0_q >> elem1));
  end

  rv32v_elem_locator #(
    .ELEM_W (ELEM_W)
  ) u_loc0 (
    .elem    (elem0),
    .sew     (sew_q),
    .vd      (vd_q),
    .woffset (io.woffset0),
    .vd_sel  (io.vd_sel0)
  );

  rv32v_elem_locator #(
    .ELEM_W (ELEM_W)
  ) u_loc1 (
    .elem    (elem1),
    .sew     (sew_q),
    .vd      (vd_q),
    .woffset (io.woffset1),
    .vd_sel  (io.vd_sel1)
  );

endmodule
